lsu_master: RTL and testbench
=============================

Name: lsu_master

Overview:
- Load/store initiator between core datapath and word-organised data memory.
- Accepts one byte/half/word access, encoded by RISC-V funct3, over a valid/ready handshake.
- Issues a single word-aligned, byte-enabled request to memory over a req/gnt/rvalid protocol.
- Returns load data sign- or zero-extended. Detects misaligned/illegal accesses and memory timeouts.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 supported.
- TIMEOUT, 15, max cycles in REQ+WAIT before abort with error; range 2..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core access request
- req_ready  out  1  LSU can accept request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid: misaligned, illegal, or timeout
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0] forced 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  completion; mem_rdata valid for loads
- mem_rdata  in  32  full read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except req_ready=1. Timeout counter 0. An in-flight transaction is abandoned; mem_req drops immediately.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata.
  - Illegal access → RESP with err=1, no memory transaction. Illegal = load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010}.
  - Misaligned access → RESP with err=1, no memory transaction. Misaligned = half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise → REQ.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata are registered and stable until gnt.
  - On mem_gnt → WAIT; mem_req deasserts the next cycle.
- WAIT:
  - On mem_rvalid → RESP. For loads, capture the extended data.
  - Stores also wait for mem_rvalid as write acknowledge.
  - mem_rvalid is never expected in the same cycle as gnt.
- RESP: rsp_valid=1 for exactly one cycle; no backpressure; → IDLE. req_ready=0 in REQ, WAIT, RESP.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT and rvalid is absent → RESP, err=1, rdata=0; mem_req is dropped.
  - rvalid coincident with the timeout cycle wins (normal completion).
  - A mem_rvalid arriving while in IDLE or RESP is ignored.
- Store lanes:
  - sb: be = 0001 << addr[1:0]; wdata = wdata[7:0] replicated ×4.
  - sh: be = 0011 if addr[1]=0, else 1100; wdata = wdata[15:0] replicated ×2.
  - sw: be = 1111.
- Load lanes:
  - be = 1111 for all loads.
  - Byte selected by addr[1:0]; half selected by addr[1].
  - b/h sign-extend from bit 7/15; bu/hu zero-extend; w passes through.
- Latency: accept at cycle 0, minimum rsp_valid at cycle 3 (gnt at 1, rvalid at 2). Error-on-accept responds at cycle 1.
- Back-to-back: a new request is accepted no earlier than the cycle after rsp_valid.

Test Plan:
1. Store word: sw addr 0x0000_0008, wdata 0xDEAD_BEEF, gnt and rvalid immediate → mem_addr 0x8, be 1111, wdata 0xDEAD_BEEF; rsp_valid at cycle 3, err 0, rdata 0.
2. Byte load sign/zero: mem_rdata 0x80FF_7F01, addr 0x...3. lb → rdata 0xFFFF_FF80; lbu → 0x0000_0080. At addr 0x...1: lb → 0x0000_007F.
3. Halfword store lanes: sh addr 0x6, wdata 0x1234_ABCD → mem_addr 0x4, be 1100, mem_wdata 0xABCD_ABCD.
4. Misaligned/illegal: lw addr 0x2 → no mem_req, rsp_valid at cycle 1, err 1. Load funct3=011 → same response.
5. Stall and timeout:
   - gnt held low 3 cycles: mem_req and fields stay stable; req_ready=0.
   - rvalid never arrives, TIMEOUT=15: rsp_valid with err 1 after 15 cycles in REQ/WAIT; a late rvalid is ignored.
6. Reset mid-WAIT: rst_n low for 1 cycle → mem_req 0, rsp_valid 0, req_ready 1 immediately. The next lw completes normally.

Source files
------------

// File: rtl/lsu_master_if.sv
// Core-side request/response and memory-side req/gnt/rvalid signals of the load/store unit.
// The master modport is the LSU's view; the slave modport is the core and memory environment's view.
interface lsu_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_master.sv
// Load/store initiator: one byte/half/word access per request, issued as a single word-aligned
// byte-enabled memory transaction, with alignment/legality checks and a REQ+WAIT timeout.
module lsu_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input logic          clk,
  input logic          rst_n,
  lsu_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;

  logic                  illegal, misaligned;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;

  // Unsigned byte/half encodings are loads only; a store with those codes is illegal.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (bus.req_funct3)
      3'b000:  ;
      3'b001:  misaligned = bus.req_addr[0];
      3'b010:  misaligned = |bus.req_addr[1:0];
      3'b100:  illegal = bus.req_we;
      3'b101: begin
        illegal    = bus.req_we;
        misaligned = bus.req_addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          be_d    = bus.req_we ? st_be : 4'b1111;
          wdata_d = bus.req_we ? st_wdata : '0;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = illegal | misaligned;
          state_d = (illegal | misaligned) ? RESP : REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LastCnt) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (bus.mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A completion in the final counted cycle still beats the timeout.
        if (bus.mem_rvalid) begin
          rdata_d = we_q ? '0 : ld_data;
          state_d = RESP;
        end else if (cnt_q == LastCnt) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the state register so reset drops mem_req without waiting for a clock.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = (state_q == REQ) & we_q;
  assign bus.mem_addr  = (state_q == REQ) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_be    = (state_q == REQ) ? be_q : '0;
  assign bus.mem_wdata = (state_q == REQ) ? wdata_q : '0;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign bus.rsp_err   = (state_q == RESP) & err_q;
endmodule

// File: tb/tb_lsu_master.sv
// Randomised scoreboard bench for lsu_master: a byte-addressed reference model predicts memory
// requests and responses, a memory responder checks requests, and a monitor checks responses.
module tb_lsu_master;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { logic err; logic [31:0] rdata; int lat; } rspT;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } memT;

  rspT         rspQ[$];
  memT         memQ[$];
  int          nCompared = 0;
  int          nMismatch = 0;
  int          doneCount = 0;
  int          curG = 0;
  int          curR = 0;
  bit          respHaveExp = 1'b0;
  bit          respGranted = 1'b0;
  logic [7:0]  refMem[int unsigned];
  logic [31:0] physMem[int unsigned];

  function automatic logic [7:0] initByte(logic [31:0] a);
    return 8'((a[7:0] * 8'd29) ^ 8'h5A);
  endfunction

  function automatic logic [7:0] refByte(logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initByte(a);
  endfunction

  function automatic logic [31:0] physWord(logic [31:0] wa);
    if (physMem.exists(wa)) return physMem[wa];
    return {initByte(wa + 3), initByte(wa + 2), initByte(wa + 1), initByte(wa)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: treats memory as bytes and the access as [addr, addr+size).
  task automatic modelIssue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit pushRsp);
    int          size;
    bit          legal, normal;
    rspT         r;
    memT         m;
    logic [31:0] wordA, val;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    if (!legal || (addr % size) != 0) begin
      r.err = 1'b1; r.rdata = '0; r.lat = 1;
      if (pushRsp) rspQ.push_back(r);
      return;
    end
    normal = (2 + curG + curR) <= TO;
    wordA  = addr & ~32'd3;
    m.we = we; m.addr = wordA; m.be = '0; m.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (!we || ((wordA + i) >= addr && (wordA + i) < (addr + size))) m.be[i] = 1'b1;
      if (we) m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    memQ.push_back(m);
    r.err = !normal; r.rdata = '0; r.lat = normal ? 3 + curG + curR : TO + 1;
    if (normal) begin
      if (we) begin
        for (int k = 0; k < size; k++) refMem[addr + k] = wdata[8*k +: 8];
      end else begin
        val = '0;
        for (int k = 0; k < size; k++) val[8*k +: 8] = refByte(addr + k);
        if (size < 4 && !f3[2] && val[8*size-1])
          for (int k = 8 * size; k < 32; k++) val[k] = 1'b1;
        r.rdata = val;
      end
    end
    if (pushRsp) rspQ.push_back(r);
  endtask

  // Memory responder: grants after curG wait cycles, completes curR cycles into WAIT.
  initial begin : responder
    memT         exp;
    int          waitCnt, rCnt;
    logic [31:0] gA, gWd, w;
    logic [3:0]  gBe;
    logic        gWe;
    waitCnt = 0; rCnt = 0; gA = '0; gWd = '0; gBe = '0; gWe = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (!rst_n) begin
        respHaveExp = 1'b0; respGranted = 1'b0;
      end else if (bus.mem_req) begin
        if (!respHaveExp) begin
          if (memQ.size() == 0) begin
            checkOutput("mem_req_unexpected", 32'd1, 32'd0);
            exp.we = bus.mem_we; exp.addr = bus.mem_addr; exp.be = bus.mem_be; exp.wdata = bus.mem_wdata;
          end else exp = memQ.pop_front();
          respHaveExp = 1'b1; waitCnt = 0;
        end
        checkOutput("mem_we", 32'(bus.mem_we), 32'(exp.we));
        checkOutput("mem_addr", bus.mem_addr, exp.addr);
        checkOutput("mem_be", 32'(bus.mem_be), 32'(exp.be));
        if (exp.we) checkOutput("mem_wdata", bus.mem_wdata, exp.wdata);
        checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (waitCnt >= curG) begin
          bus.mem_gnt = 1'b1; respGranted = 1'b1; respHaveExp = 1'b0; rCnt = 0;
          gA = bus.mem_addr; gBe = bus.mem_be; gWd = bus.mem_wdata; gWe = bus.mem_we;
        end else waitCnt++;
      end else begin
        respHaveExp = 1'b0;
        if (respGranted) begin
          if (rCnt >= curR) begin
            bus.mem_rvalid = 1'b1;
            if (gWe) begin
              w = physWord(gA);
              for (int i = 0; i < 4; i++) if (gBe[i]) w[8*i +: 8] = gWd[8*i +: 8];
              physMem[gA] = w;
            end else bus.mem_rdata = physWord(gA);
            respGranted = 1'b0;
          end else rCnt++;
        end
      end
    end
  end

  int cyc = 0;
  int acceptCyc = 0;

  always @(negedge clk) begin : monitor
    rspT e;
    cyc++;
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) acceptCyc = cyc;
      if (bus.rsp_valid) begin
        if (rspQ.size() == 0) checkOutput("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = rspQ.pop_front();
          checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
          checkOutput("rsp_latency", 32'(cyc - acceptCyc), 32'(e.lat));
        end
        doneCount++;
      end
    end
  end

  task automatic driveReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && (respGranted || respHaveExp); i++) @(negedge clk);
    if (respGranted || respHaveExp) checkOutput("responder_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int g, input int r);
    int start;
    waitIdle();
    curG = g; curR = r; start = doneCount;
    modelIssue(we, f3, addr, wdata, 1'b1);
    driveReq(we, f3, addr, wdata);
    for (int i = 0; i < 80 && doneCount == start; i++) @(negedge clk);
    if (doneCount == start) checkOutput("rsp_wait_timeout", 32'd1, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [2:0] f3;
    logic       we;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_mem_be", 32'(bus.mem_be), 32'd0);
    checkOutput("reset_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    physMem[32'h100] = 32'h80FF_7F01;
    refMem[32'h100] = 8'h01; refMem[32'h101] = 8'h7F; refMem[32'h102] = 8'hFF; refMem[32'h103] = 8'h80;

    applyStimulus(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 0, 0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0008, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b000, 32'h0000_0101, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 0);
    applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 1);

    applyStimulus(1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 1, 1);
    applyStimulus(1'b1, 3'b000, 32'h0000_0005, 32'h0000_0077, 0, 2);
    applyStimulus(1'b0, 3'b010, 32'h0000_0004, 32'h0, 0, 0);

    applyStimulus(1'b0, 3'b010, 32'h0000_0002, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'h0, 0, 0);
    applyStimulus(1'b1, 3'b100, 32'h0000_0000, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b001, 32'h0000_0001, 32'h0, 0, 0);

    applyStimulus(1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 3, 2);
    applyStimulus(1'b0, 3'b010, 32'h0000_0024, 32'h0, 0, 20);
    applyStimulus(1'b0, 3'b010, 32'h0000_0020, 32'h0, 0, TO - 2);
    applyStimulus(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5, TO - 6);
    applyStimulus(1'b0, 3'b000, 32'h0000_0021, 32'h0, 40, 0);

    // Abort a load mid-WAIT with a one-cycle reset pulse.
    waitIdle();
    curG = 0; curR = 30;
    modelIssue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0);
    driveReq(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midreset_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        f3 = 3'($urandom_range(0, 2));
        if (!we && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3 = f3 | 3'b100;
      end else f3 = 3'($urandom);
      applyStimulus(we, f3, 32'h40 + 32'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3));
    end

    waitIdle();
    repeat (5) @(negedge clk);
    checkOutput("rsp_queue_drained", 32'(rspQ.size()), 32'd0);
    checkOutput("mem_queue_drained", 32'(memQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
